// File: rtl/pipe_mux.sv
// rtl/pipe_mux.sv - pipelined N:1 lane multiplexer built as a registered radix-R tree
// Each tree level is one register stage with its own valid/ready handshake; out-of-range selects yield y=0 with oor set.
module pipe_mux #(
  parameter int W = 1,
  parameter int N = 16,
  parameter int R = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N*W-1:0]         i,
  input  logic [$clog2(N)-1:0]   s,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [W-1:0]           y,
  output logic                   oor,
  output logic                   out_valid,
  input  logic                   out_ready
);

  function automatic int calc_depth(int n, int r);
    int d;
    int p;
    d = 1;
    p = r;
    while (p < n) begin
      p = p * r;
      d++;
    end
    return d;
  endfunction

  localparam int RB = $clog2(R);
  localparam int L  = calc_depth(N, R);
  localparam int LS = L * RB;
  localparam int NP = R ** L;

  logic [NP*W-1:0] i_pad;
  logic [LS-1:0]   s_ext;
  logic            s_oor;

  assign i_pad = (NP*W)'(i);
  assign s_ext = LS'(s);
  assign s_oor = (int'(s) >= N);

  logic [L-1:0] v_q, v_d, oor_q, oor_d, ld, up_v, up_oor;
  logic         rdy0;

  assign up_v[0]   = in_valid;
  assign up_oor[0] = s_oor;
  for (genvar k = 1; k < L; k++) begin : g_up
    assign up_v[k]   = v_q[k-1];
    assign up_oor[k] = oor_q[k-1];
  end

  // Walk from the output back to the input so each stage sees its downstream ready.
  always_comb begin : flow
    logic r;
    logic l;
    ld    = '0;
    v_d   = '0;
    oor_d = '0;
    r     = out_ready;
    l     = 1'b0;
    for (int k = L - 1; k >= 0; k--) begin
      l        = up_v[k] && (!v_q[k] || r);
      ld[k]    = l;
      v_d[k]   = l || (v_q[k] && !r);
      oor_d[k] = l ? up_oor[k] : oor_q[k];
      r        = !v_q[k] || r;
    end
    rdy0 = r;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q   <= '0;
      oor_q <= '0;
    end else begin
      v_q   <= v_d;
      oor_q <= oor_d;
    end
  end

  for (genvar k = 0; k < L; k++) begin : g_stage
    localparam int CI = R ** (L - k);
    localparam int CO = R ** (L - 1 - k);
    localparam int SI = (L - k) * RB;

    logic [CI*W-1:0] cin;
    logic [SI-1:0]   sin;
    logic [CO*W-1:0] cand_d, cand_q;

    if (k == 0) begin : g_in
      assign cin = i_pad;
      assign sin = s_ext;
    end else begin : g_in
      assign cin = g_stage[k-1].cand_q;
      assign sin = g_stage[k-1].g_sel.sel_q;
    end

    always_comb begin
      cand_d = cand_q;
      if (ld[k]) begin
        for (int j = 0; j < CO; j++) begin
          for (int m = 0; m < R; m++) begin
            if (sin[RB-1:0] == RB'(m)) cand_d[j*W +: W] = cin[(j*R+m)*W +: W];
          end
        end
        if (k == L - 1 && up_oor[k]) cand_d = '0;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) cand_q <= '0;
      else     cand_q <= cand_d;
    end

    if (k < L - 1) begin : g_sel
      logic [SI-RB-1:0] sel_d, sel_q;

      always_comb begin
        sel_d = sel_q;
        if (ld[k]) sel_d = sin[SI-1:RB];
      end

      always_ff @(posedge clk) begin
        if (rst) sel_q <= '0;
        else     sel_q <= sel_d;
      end
    end
  end

  assign in_ready  = rdy0 && !rst;
  assign out_valid = v_q[L-1];
  assign oor       = oor_q[L-1];
  assign y         = g_stage[L-1].cand_q;

endmodule

// File: tb/tb_pipe_mux.sv
// tb/tb_pipe_mux.sv - directed and randomized checks of pipe_mux in three configurations
module tb_pipe_mux;

  logic clk;
  logic rst;

  logic [127:0] i_a;
  logic [3:0]   s_a;
  logic         iv_a, ir_a, ov_a, or_a, oor_a;
  logic [7:0]   y_a;

  logic [39:0]  i_b;
  logic [2:0]   s_b;
  logic         iv_b, ir_b, ov_b, or_b, oor_b;
  logic [7:0]   y_b;

  logic [1:0]   i_c;
  logic [0:0]   s_c;
  logic         iv_c, ir_c, ov_c, or_c, oor_c;
  logic [0:0]   y_c;

  int n_cmp;
  int n_err;

  logic [2:0] sb_v [5] = '{3'd4, 3'd5, 3'd6, 3'd7, 3'd3};
  logic [7:0] yb_e [5] = '{8'hB4, 8'h00, 8'h00, 8'h00, 8'hB3};
  logic       ob_e [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

  logic [8:0] sb_q[$];

  pipe_mux #(.W(8), .N(16), .R(4)) dut_a (
    .clk(clk), .rst(rst), .i(i_a), .s(s_a), .in_valid(iv_a), .in_ready(ir_a),
    .y(y_a), .oor(oor_a), .out_valid(ov_a), .out_ready(or_a)
  );

  pipe_mux #(.W(8), .N(5), .R(2)) dut_b (
    .clk(clk), .rst(rst), .i(i_b), .s(s_b), .in_valid(iv_b), .in_ready(ir_b),
    .y(y_b), .oor(oor_b), .out_valid(ov_b), .out_ready(or_b)
  );

  pipe_mux #(.W(1), .N(2), .R(2)) dut_c (
    .clk(clk), .rst(rst), .i(i_c), .s(s_c), .in_valid(iv_c), .in_ready(ir_c),
    .y(y_c), .oor(oor_c), .out_valid(ov_c), .out_ready(or_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    int first;
    int idx;
    logic [8:0] e;

    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    iv_a = 0; s_a = '0; or_a = 0;
    iv_b = 0; s_b = '0; or_b = 0;
    iv_c = 0; s_c = '0; or_c = 1;
    for (int k = 0; k < 16; k++) i_a[k*8 +: 8] = 8'hA0 + 8'(k);
    for (int k = 0; k < 5; k++)  i_b[k*8 +: 8] = 8'hB0 + 8'(k);
    i_c = 2'b10;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_ov", ov_a, 0);
    chk("rst_y", y_a, 0);
    chk("rst_oor", oor_a, 0);
    chk("rst_ir", ir_a, 0);
    chk("rst_ov_b", ov_b, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("empty_ir", ir_a, 1);
    chk("empty_ov", ov_a, 0);

    // Full-rate stream through the two-level tree.
    or_a = 1; first = -1; idx = 0;
    for (int c = 0; c < 22; c++) begin
      @(negedge clk);
      iv_a = (c < 16);
      s_a = 4'(c);
      #1;
      if (c < 16) chk("a_ir", ir_a, 1);
      if (ov_a) begin
        if (first < 0) first = c;
        chk("a_y", y_a, 8'hA0 + 8'(idx));
        chk("a_oor", oor_a, 0);
        idx++;
      end
    end
    chk("a_lat", first, 2);
    chk("a_cnt", idx, 16);
    iv_a = 0;

    // Three-level tree with padded lanes and out-of-range selects.
    or_b = 1; first = -1; idx = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      iv_b = (c < 5);
      if (c < 5) s_b = sb_v[c];
      #1;
      if (ov_b) begin
        if (first < 0) first = c;
        if (idx < 5) begin
          chk("b_y", y_b, yb_e[idx]);
          chk("b_oor", oor_b, ob_e[idx]);
        end
        idx++;
      end
    end
    chk("b_lat", first, 3);
    chk("b_cnt", idx, 5);
    iv_b = 0;

    // Backpressure: two stages fill, third item waits until out_ready rises.
    @(negedge clk); or_a = 0; iv_a = 1; s_a = 4'd1; #1;
    chk("bp_ir0", ir_a, 1);
    @(negedge clk); s_a = 4'd2; #1;
    chk("bp_ir1", ir_a, 1);
    chk("bp_ov1", ov_a, 0);
    @(negedge clk); s_a = 4'd3; #1;
    chk("bp_ir2", ir_a, 0);
    chk("bp_ov2", ov_a, 1);
    chk("bp_y2", y_a, 8'hA1);
    @(negedge clk); #1;
    chk("bp_hold_y", y_a, 8'hA1);
    chk("bp_hold_ir", ir_a, 0);
    @(negedge clk); or_a = 1; #1;
    chk("bp_rise_ir", ir_a, 1);
    chk("bp_rise_y", y_a, 8'hA1);
    @(negedge clk); iv_a = 0; #1;
    chk("bp_ov_2nd", ov_a, 1);
    chk("bp_y_2nd", y_a, 8'hA2);
    @(negedge clk); #1;
    chk("bp_ov_3rd", ov_a, 1);
    chk("bp_y_3rd", y_a, 8'hA3);
    @(negedge clk); #1;
    chk("bp_drained", ov_a, 0);

    // Reset with two results in flight.
    @(negedge clk); or_a = 0; iv_a = 1; s_a = 4'd5;
    @(negedge clk); s_a = 4'd6;
    @(negedge clk); iv_a = 0; rst = 1'b1; #1;
    chk("mid_pre_y", y_a, 8'hA5);
    chk("mid_rst_ir", ir_a, 0);
    @(negedge clk); rst = 1'b0; or_a = 1; #1;
    chk("mid_ov", ov_a, 0);
    chk("mid_y", y_a, 0);
    chk("mid_oor", oor_a, 0);
    chk("mid_ir", ir_a, 1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      chk("mid_gone", ov_a, 0);
    end

    // Single-level degenerate case.
    @(negedge clk); iv_c = 1; s_c = 1'b1; #1;
    chk("c_ir", ir_c, 1);
    @(negedge clk); s_c = 1'b0; #1;
    chk("c_ov1", ov_c, 1);
    chk("c_y1", y_c, 1);
    @(negedge clk); iv_c = 0; #1;
    chk("c_ov0", ov_c, 1);
    chk("c_y0", y_c, 0);
    @(negedge clk); #1;
    chk("c_empty", ov_c, 0);

    // Random valid/ready with a scoreboard on the N=5 instance.
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      iv_b = 1'($urandom_range(0, 1));
      or_b = ($urandom_range(0, 3) != 0);
      i_b = 40'({$urandom, $urandom});
      s_b = 3'($urandom_range(0, 7));
      #1;
      if (iv_b && ir_b) begin
        if (s_b >= 3'd5) sb_q.push_back(9'h100);
        else sb_q.push_back({1'b0, i_b[int'(s_b)*8 +: 8]});
      end
      if (ov_b && or_b) begin
        chk("rnd_q_nonempty", (sb_q.size() > 0), 1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          chk("rnd_y", {oor_b, y_b}, e);
        end
      end
    end
    iv_b = 0; or_b = 1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); #1;
      if (ov_b) begin
        chk("rnd_q_nonempty", (sb_q.size() > 0), 1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          chk("rnd_y", {oor_b, y_b}, e);
        end
      end
    end
    chk("rnd_left", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
